// File: rtl/bram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bram_arbiter_if                                                 |
// | Brief    : Requester and bram-side signal bundle for bram_arbiter.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface bram_arbiter_if #(
    parameter int RAM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  w0_req;
    logic                  w1_req;
    logic                  w0_lock;
    logic                  w1_lock;
    logic [ADDR_WIDTH-1:0] w0_addr;
    logic [ADDR_WIDTH-1:0] w1_addr;
    logic [RAM_WIDTH-1:0]  w0_data;
    logic [RAM_WIDTH-1:0]  w1_data;
    logic                  w0_gnt;
    logic                  w1_gnt;

    logic                  r0_req;
    logic                  r1_req;
    logic                  r0_lock;
    logic                  r1_lock;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic                  r0_gnt;
    logic                  r1_gnt;
    logic                  r0_valid;
    logic                  r1_valid;
    logic [RAM_WIDTH-1:0]  r_data;

    logic                  bram_wr_en;
    logic [ADDR_WIDTH-1:0] bram_wr_addr;
    logic [RAM_WIDTH-1:0]  bram_wr_data;
    logic                  bram_rd_en;
    logic [ADDR_WIDTH-1:0] bram_rd_addr;
    logic [RAM_WIDTH-1:0]  bram_rd_data;

    modport slave (
        input  w0_req, w1_req, w0_lock, w1_lock, w0_addr, w1_addr, w0_data, w1_data,
        input  r0_req, r1_req, r0_lock, r1_lock, r0_addr, r1_addr,
        input  bram_rd_data,
        output w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_valid, r1_valid, r_data,
        output bram_wr_en, bram_wr_addr, bram_wr_data, bram_rd_en, bram_rd_addr
    );

    modport master (
        output w0_req, w1_req, w0_lock, w1_lock, w0_addr, w1_addr, w0_data, w1_data,
        output r0_req, r1_req, r0_lock, r1_lock, r0_addr, r1_addr,
        output bram_rd_data,
        input  w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_valid, r1_valid, r_data,
        input  bram_wr_en, bram_wr_addr, bram_wr_data, bram_rd_en, bram_rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bram_arbiter                                                    |
// | Brief    : Round-robin write/read port arbiter with locked bursts for bram.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bram_arbiter #(
    parameter int RAM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bram_arbiter_if.slave   bus
);
    localparam logic [1:0] c_ST_ARB   = 2'd0;
    localparam logic [1:0] c_ST_HOLD0 = 2'd1;
    localparam logic [1:0] c_ST_HOLD1 = 2'd2;

    // Index 0 is the write port, index 1 the read port; bit k is requester k.
    logic [1:0][1:0] w_req;
    logic [1:0][1:0] w_lock;
    logic [1:0][1:0] w_gnt;
    logic [1:0]      r_valid;

    assign w_req[0]  = {bus.w1_req,  bus.w0_req};
    assign w_req[1]  = {bus.r1_req,  bus.r0_req};
    assign w_lock[0] = {bus.w1_lock, bus.w0_lock};
    assign w_lock[1] = {bus.r1_lock, bus.r0_lock};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [1:0] r_state;
        logic [1:0] w_state_nxt;
        logic       r_last;
        logic [1:0] w_rq;
        logic [1:0] w_lk;
        logic [1:0] w_g;

        assign w_rq = w_req[p];
        assign w_lk = w_lock[p];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= c_ST_ARB;
                r_last  <= 1'b1;
            end else begin
                r_state <= w_state_nxt;
                if (|w_g) begin
                    r_last <= w_g[1];
                end
            end
        end

        // A dropped lock or request releases the port in the same cycle.
        always_comb begin
            w_g = 2'b00;
            if (r_state == c_ST_HOLD0 && w_rq[0] && w_lk[0]) begin
                w_g = 2'b01;
            end else if (r_state == c_ST_HOLD1 && w_rq[1] && w_lk[1]) begin
                w_g = 2'b10;
            end else if (&w_rq) begin
                w_g = r_last ? 2'b01 : 2'b10;
            end else begin
                w_g = w_rq;
            end
            if (!rst_n) begin
                w_g = 2'b00;
            end
        end

        always_comb begin
            w_state_nxt = c_ST_ARB;
            if (w_g[0] && w_lk[0]) begin
                w_state_nxt = c_ST_HOLD0;
            end else if (w_g[1] && w_lk[1]) begin
                w_state_nxt = c_ST_HOLD1;
            end
        end

        assign w_gnt[p] = w_g;
    end

    always_comb begin
        bus.bram_wr_addr = '0;
        bus.bram_wr_data = '0;
        if (w_gnt[0][0]) begin
            bus.bram_wr_addr = bus.w0_addr;
            bus.bram_wr_data = bus.w0_data;
        end else if (w_gnt[0][1]) begin
            bus.bram_wr_addr = bus.w1_addr;
            bus.bram_wr_data = bus.w1_data;
        end
    end

    always_comb begin
        bus.bram_rd_addr = '0;
        if (w_gnt[1][0]) begin
            bus.bram_rd_addr = bus.r0_addr;
        end else if (w_gnt[1][1]) begin
            bus.bram_rd_addr = bus.r1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 2'b00;
        end else begin
            r_valid <= w_gnt[1];
        end
    end

    assign bus.w0_gnt     = w_gnt[0][0];
    assign bus.w1_gnt     = w_gnt[0][1];
    assign bus.r0_gnt     = w_gnt[1][0];
    assign bus.r1_gnt     = w_gnt[1][1];
    assign bus.bram_wr_en = |w_gnt[0];
    assign bus.bram_rd_en = |w_gnt[1];

    // Masked so a read granted just before reset never shows valid.
    assign bus.r0_valid   = r_valid[0] & rst_n;
    assign bus.r1_valid   = r_valid[1] & rst_n;
    assign bus.r_data     = bus.bram_rd_data;
endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bram_arbiter                                                 |
// | Brief    : Directed and random checks of bram_arbiter against a ref model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_bram_arbiter;
    localparam int RAM_WIDTH  = 8;
    localparam int ADDR_WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.RAM_WIDTH(RAM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    bram_arbiter #(.RAM_WIDTH(RAM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Attached bram: synchronous write, registered read returning old contents.
    logic [7:0] bram_mem [16];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) bram_mem[i] <= 8'h00;
            mem_ready <= 1'b1;
        end else begin
            if (bus.bram_wr_en) bram_mem[bus.bram_wr_addr] <= bus.bram_wr_data;
            if (bus.bram_rd_en) bus.bram_rd_data <= bram_mem[bus.bram_rd_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_hold [2];
    int         m_last [2];
    logic [1:0] m_pend;
    logic [7:0] m_pend_data;
    logic [7:0] m_mem [16];

    logic [1:0] obs_wgnt, obs_rgnt, obs_valid;
    logic [7:0] seen_r0, seen_r1;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic q0, q1, k0, k1, input int hold, input int last);
        if (hold == 0 && q0 && k0) return 0;
        if (hold == 1 && q1 && k1) return 1;
        if (q0 && q1) return 1 - last;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        if (g == 0) return 2'b01;
        if (g == 1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int next_hold(input int g, input logic k0, k1);
        if (g == 0 && k0) return 0;
        if (g == 1 && k1) return 1;
        return -1;
    endfunction

    // Inputs are set before calling; compares at the falling edge, then the model steps.
    task automatic tick();
        int         gw, gr;
        logic [3:0] wa, ra;
        logic [7:0] wd;
        logic [1:0] exp_valid;
        @(negedge clk);
        obs_wgnt  = {bus.w1_gnt, bus.w0_gnt};
        obs_rgnt  = {bus.r1_gnt, bus.r0_gnt};
        obs_valid = {bus.r1_valid, bus.r0_valid};
        if (obs_valid[0]) seen_r0 = bus.r_data;
        if (obs_valid[1]) seen_r1 = bus.r_data;
        gw = -1;
        gr = -1;
        if (rst_n) begin
            gw = pick(bus.w0_req, bus.w1_req, bus.w0_lock, bus.w1_lock, m_hold[0], m_last[0]);
            gr = pick(bus.r0_req, bus.r1_req, bus.r0_lock, bus.r1_lock, m_hold[1], m_last[1]);
        end
        wa = (gw == 0) ? bus.w0_addr : (gw == 1) ? bus.w1_addr : 4'h0;
        wd = (gw == 0) ? bus.w0_data : (gw == 1) ? bus.w1_data : 8'h00;
        ra = (gr == 0) ? bus.r0_addr : (gr == 1) ? bus.r1_addr : 4'h0;
        exp_valid = rst_n ? m_pend : 2'b00;

        check_value("w_gnt",   32'(obs_wgnt), 32'(onehot(gw)));
        check_value("r_gnt",   32'(obs_rgnt), 32'(onehot(gr)));
        check_value("wr_en",   32'(bus.bram_wr_en), 32'(gw >= 0));
        check_value("wr_addr", 32'(bus.bram_wr_addr), 32'(wa));
        check_value("wr_data", 32'(bus.bram_wr_data), 32'(wd));
        check_value("rd_en",   32'(bus.bram_rd_en), 32'(gr >= 0));
        check_value("rd_addr", 32'(bus.bram_rd_addr), 32'(ra));
        check_value("valid",   32'(obs_valid), 32'(exp_valid));
        if (exp_valid != 2'b00) check_value("r_data", 32'(bus.r_data), 32'(m_pend_data));

        if (!rst_n) begin
            m_hold = '{-1, -1};
            m_last = '{1, 1};
            m_pend = 2'b00;
        end else begin
            m_pend = onehot(gr);
            if (gr >= 0) m_pend_data = m_mem[ra];
            if (gw >= 0) m_mem[wa] = wd;
            m_hold[0] = next_hold(gw, bus.w0_lock, bus.w1_lock);
            m_hold[1] = next_hold(gr, bus.r0_lock, bus.r1_lock);
            if (gw >= 0) m_last[0] = gw;
            if (gr >= 0) m_last[1] = gr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.w0_req = 0; bus.w1_req = 0; bus.w0_lock = 0; bus.w1_lock = 0;
        bus.r0_req = 0; bus.r1_req = 0; bus.r0_lock = 0; bus.r1_lock = 0;
        bus.w0_addr = 0; bus.w1_addr = 0; bus.w0_data = 0; bus.w1_data = 0;
        bus.r0_addr = 0; bus.r1_addr = 0;
    endtask

    initial begin
        idle_all();
        m_hold = '{-1, -1};
        m_last = '{1, 1};
        m_pend = 2'b00;
        m_pend_data = 8'h00;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        seen_r0 = 8'h00;
        seen_r1 = 8'h00;

        // Reset with every request high
        bus.w0_req = 1; bus.w1_req = 1; bus.r0_req = 1; bus.r1_req = 1;
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("rst_wgnt", 32'(obs_wgnt), 32'd0);
            check_value("rst_valid", 32'(obs_valid), 32'd0);
        end
        rst_n = 1;
        tick();
        check_value("rel_wgnt", 32'(obs_wgnt), 32'b01);
        check_value("rel_rgnt", 32'(obs_rgnt), 32'b01);

        // Write contention: last writer was 0, so 1 leads
        idle_all();
        bus.w0_req = 1; bus.w0_addr = 4'h1; bus.w0_data = 8'h31;
        bus.w1_req = 1; bus.w1_addr = 4'h2; bus.w1_data = 8'h42;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_value("wr_alt", 32'(obs_wgnt), (i % 2 == 0) ? 32'b10 : 32'b01);
        end

        // Locked burst by writer 1
        bus.w1_lock = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("burst_w1", 32'(obs_wgnt), 32'b10);
        end
        bus.w1_lock = 0;
        tick();
        check_value("burst_w0", 32'(obs_wgnt), 32'b01);
        idle_all();
        tick();

        // Read return tagging
        bus.w0_req = 1; bus.w0_addr = 4'h3; bus.w0_data = 8'hA5;
        tick();
        bus.w0_addr = 4'h7; bus.w0_data = 8'h5A;
        tick();
        idle_all();
        bus.r0_req = 1; bus.r0_addr = 4'h3;
        bus.r1_req = 1; bus.r1_addr = 4'h7;
        tick();
        tick();
        idle_all();
        tick();
        tick();
        check_value("tag_r0", 32'(seen_r0), 32'hA5);
        check_value("tag_r1", 32'(seen_r1), 32'h5A);

        // Same-address collision
        bus.w0_req = 1; bus.w0_addr = 4'h2; bus.w0_data = 8'h11;
        tick();
        bus.w0_data = 8'h22;
        bus.r0_req = 1; bus.r0_addr = 4'h2;
        tick();
        bus.w0_req = 0;
        tick();
        check_value("coll_old", 32'(seen_r0), 32'h11);
        idle_all();
        tick();
        check_value("coll_new", 32'(seen_r0), 32'h22);

        // Reset in the middle of a locked read burst
        bus.r1_req = 1; bus.r1_lock = 1; bus.r1_addr = 4'h7;
        tick();
        check_value("mb_r1", 32'(obs_rgnt), 32'b10);
        bus.r0_req = 1;
        rst_n = 0;
        tick();
        check_value("mb_valid0", 32'(obs_valid), 32'd0);
        tick();
        check_value("mb_valid1", 32'(obs_valid), 32'd0);
        rst_n = 1;
        bus.r1_lock = 0;
        tick();
        check_value("mb_r0win", 32'(obs_rgnt), 32'b01);
        check_value("mb_valid2", 32'(obs_valid), 32'd0);
        idle_all();
        tick();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            bus.w0_req  = 1'($urandom);      bus.w1_req  = 1'($urandom);
            bus.w0_lock = 1'($urandom);      bus.w1_lock = 1'($urandom);
            bus.r0_req  = 1'($urandom);      bus.r1_req  = 1'($urandom);
            bus.r0_lock = 1'($urandom);      bus.r1_lock = 1'($urandom);
            bus.w0_addr = 4'($urandom);      bus.w1_addr = 4'($urandom);
            bus.w0_data = 8'($urandom);      bus.w1_data = 8'($urandom);
            bus.r0_addr = 4'($urandom);      bus.r1_addr = 4'($urandom);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
        end
        rst_n = 1;
        idle_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
